// File: rtl/dataset_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// dataset_load_ctrl_if
//
// Groups the three data-path handshakes driven by the dataset load sequencer:
//   - deserializer : des_en (enable), des_word / des_valid (assembled word strobe)
//   - RAM write    : ram_we / ram_ready (write handshake), ram_addr, ram_wdata
//   - compute core : core_start (one-cycle pulse), core_done (completion strobe)
//
// Modports:
//   master - the sequencer side (drives des_en, ram_*, core_start)
//   slave  - the environment side (deserializer, RAM and compute core)
//
// Parameters:
//   MAX_FEATURES - maximum feature count per data point
//   DATA_WIDTH   - word width, one 16-bit lane per feature plus one for y
//   ADDR_WIDTH   - RAM address width
// -----------------------------------------------------------------------------
interface dataset_load_ctrl_if #(
  parameter int MAX_FEATURES = 6,
  parameter int DATA_WIDTH   = 16 * (MAX_FEATURES + 1),
  parameter int ADDR_WIDTH   = 10
);

  // Deserializer side
  logic                  des_en;
  logic [DATA_WIDTH-1:0] des_word;
  logic                  des_valid;

  // Dataset RAM write port
  logic                  ram_we;
  logic                  ram_ready;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  // Compute core handshake
  logic                  core_start;
  logic                  core_done;

  modport master (
    output des_en,
    input  des_word,
    input  des_valid,
    output ram_we,
    input  ram_ready,
    output ram_addr,
    output ram_wdata,
    output core_start,
    input  core_done
  );

  modport slave (
    input  des_en,
    output des_word,
    output des_valid,
    input  ram_we,
    output ram_ready,
    input  ram_addr,
    input  ram_wdata,
    input  core_start,
    output core_done
  );

endinterface : dataset_load_ctrl_if

// File: rtl/dataset_load_ctrl.sv
// -----------------------------------------------------------------------------
// dataset_load_ctrl
//
// Sequencer for the dataset-loading path of the regression engine. It enables
// the serial deserializer, takes each assembled data-point word, masks the
// unused feature lanes and writes the word into the dataset RAM at consecutive
// addresses. After the last point it pulses core_start, waits for core_done
// and then reports completion. Bad configurations and deserializer overruns
// land in ERR.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst_n      - asynchronous active-low reset, forces IDLE and clears outputs
//   start      - start request, only honoured in IDLE/DONE/ERR
//   num_dp     - number of data points to load (latched on accepted start)
//   feat       - feature count (latched on accepted start)
//   busy       - high in LOAD, WRITE, START, RUN
//   done       - high in DONE until the next accepted start
//   err        - high in ERR until the next accepted start or reset
//   bus        - master side of dataset_load_ctrl_if (deserializer, RAM
//                write port, compute core handshake)
//
// Every output is driven from a register; ram_addr is the low bits of the
// point counter register.
// -----------------------------------------------------------------------------
module dataset_load_ctrl #(
  parameter int MAX_FEATURES = 6,
  parameter int DATA_WIDTH   = 16 * (MAX_FEATURES + 1),
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [11:0]               num_dp,
  input  logic [3:0]                feat,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  dataset_load_ctrl_if.master       bus
);

  localparam int LANE_W    = 16;
  localparam int NUM_LANES = MAX_FEATURES + 1;
  localparam int CNT_W     = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_START,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      num_dp_reg;
  logic [3:0]            feat_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  des_en_reg;
  logic                  ram_we_reg;
  logic                  core_start_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;

  logic [DATA_WIDTH-1:0] lane_mask;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  cfg_bad;
  logic                  can_start;

  // ---------------------------------------------------------------------------
  // Lane mask: lanes 0..feat_reg pass (features plus y), higher lanes are
  // zeroed. Built from the latched feature count so the mask is stable for
  // the whole run regardless of what the feat input does afterwards.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_mask
      assign lane_mask[gi*LANE_W +: LANE_W] =
        (feat_reg >= 4'(gi)) ? {LANE_W{1'b1}} : {LANE_W{1'b0}};
    end
  endgenerate

  // Configuration check uses the live inputs so an invalid start is visible
  // as err on the very next cycle.
  assign cfg_bad = (feat == 4'd0) ||
                   (feat > 4'(MAX_FEATURES)) ||
                   (num_dp == '0) ||
                   (num_dp > CNT_W'(DEPTH));

  assign cnt_inc   = cnt_reg + 1'b1;
  assign can_start = (state_reg == S_IDLE) || (state_reg == S_DONE) ||
                     (state_reg == S_ERR);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      num_dp_reg     <= '0;
      feat_reg       <= '0;
      wdata_reg      <= '0;
      des_en_reg     <= 1'b0;
      ram_we_reg     <= 1'b0;
      core_start_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (can_start && start) begin
            num_dp_reg <= num_dp;
            feat_reg   <= feat;
            done_reg   <= 1'b0;
            if (cfg_bad) begin
              err_reg   <= 1'b1;
              state_reg <= S_ERR;
            end else begin
              err_reg    <= 1'b0;
              cnt_reg    <= '0;
              des_en_reg <= 1'b1;
              busy_reg   <= 1'b1;
              state_reg  <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (bus.des_valid) begin
            wdata_reg  <= bus.des_word & lane_mask;
            ram_we_reg <= 1'b1;
            state_reg  <= S_WRITE;
          end
        end

        S_WRITE: begin
          // A new word while a write is still pending (including the accept
          // cycle itself) is an overrun: the pending write is abandoned.
          if (bus.des_valid) begin
            ram_we_reg <= 1'b0;
            des_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b1;
            state_reg  <= S_ERR;
          end else if (bus.ram_ready) begin
            ram_we_reg <= 1'b0;
            cnt_reg    <= cnt_inc;
            if (cnt_inc == num_dp_reg) begin
              des_en_reg     <= 1'b0;
              core_start_reg <= 1'b1;
              state_reg      <= S_START;
            end else begin
              state_reg <= S_LOAD;
            end
          end
        end

        S_START: begin
          core_start_reg <= 1'b0;
          state_reg      <= S_RUN;
        end

        S_RUN: begin
          if (bus.core_done) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.des_en     = des_en_reg;
  assign bus.ram_we     = ram_we_reg;
  assign bus.ram_addr   = cnt_reg[ADDR_WIDTH-1:0];
  assign bus.ram_wdata  = wdata_reg;
  assign bus.core_start = core_start_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign err            = err_reg;

endmodule : dataset_load_ctrl

// File: tb/tb_dataset_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dataset_load_ctrl
//
// Directed bench for dataset_load_ctrl. Inputs change 1 ns after the rising
// edge and outputs are checked at that point, so each check sees the state
// produced by the edge just passed. Accepted RAM writes and core_start pulses
// are tallied on the falling edge.
// -----------------------------------------------------------------------------
module tb_dataset_load_ctrl;

  localparam int MAXF = 6;
  localparam int DW   = 16 * (MAXF + 1);
  localparam int AW   = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [11:0]   num_dp;
  logic [3:0]    feat;
  logic          busy;
  logic          done;
  logic          err;

  int tests_run;
  int tests_failed;
  int wr_cnt;
  int cs_cnt;

  dataset_load_ctrl_if #(.MAX_FEATURES(MAXF), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dataset_load_ctrl #(
    .MAX_FEATURES(MAXF),
    .DATA_WIDTH  (DW),
    .DEPTH       (1024),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .num_dp(num_dp),
    .feat  (feat),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ram_we && bus.ram_ready) wr_cnt <= wr_cnt + 1;
    if (bus.core_start) cs_cnt <= cs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [11:0] n, input logic [3:0] f);
    start  = 1'b1;
    num_dp = n;
    feat   = f;
    step();
    start  = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    bus.des_word  = w;
    bus.des_valid = 1'b1;
    step();
    bus.des_valid = 1'b0;
  endtask

  task automatic finish_core();
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
  endtask

  // Lane k of point i holds 0x1000*(i+1) + k.
  function automatic logic [DW-1:0] mk_word(input int i);
    logic [DW-1:0] w;
    for (int k = 0; k <= MAXF; k++) w[k*16 +: 16] = 16'((i + 1) * 16'h1000 + k);
    return w;
  endfunction

  logic [DW-1:0] w;
  logic [DW-1:0] all_ones;
  int            wr0;
  int            cs0;

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    wr_cnt        = 0;
    cs_cnt        = 0;
    rst_n         = 1'b0;
    start         = 1'b0;
    num_dp        = '0;
    feat          = '0;
    bus.des_word  = '0;
    bus.des_valid = 1'b0;
    bus.ram_ready = 1'b1;
    bus.core_done = 1'b0;
    all_ones      = '1;

    // ---------------- reset state ----------------
    #3;
    check("rst_flags", {bus.des_en, bus.ram_we, bus.core_start, busy, done, err}, 6'b0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_wdata", bus.ram_wdata, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // ---------------- normal run: feat=6, num_dp=4 ----------------
    wr0 = wr_cnt;
    cs0 = cs_cnt;
    do_start(12'd4, 4'd6);
    check("norm_busy", busy, 1);
    check("norm_des_en", bus.des_en, 1);
    for (int i = 0; i < 4; i++) begin
      repeat (6) step();
      w = mk_word(i);
      send_word(w);
      check($sformatf("norm_we%0d", i), bus.ram_we, 1);
      check($sformatf("norm_addr%0d", i), bus.ram_addr, i);
      check($sformatf("norm_data%0d", i), bus.ram_wdata, w);
      step();
      if (i < 3) begin
        check($sformatf("norm_we_drop%0d", i), bus.ram_we, 0);
      end else begin
        check("norm_core_start", bus.core_start, 1);
        check("norm_busy_start", busy, 1);
        check("norm_des_en_off", bus.des_en, 0);
      end
    end
    step();
    check("norm_core_start_1cyc", bus.core_start, 0);
    check("norm_busy_run", busy, 1);
    finish_core();
    check("norm_done", done, 1);
    check("norm_busy_done", busy, 0);
    check("norm_writes", wr_cnt - wr0, 4);
    check("norm_cs_pulses", cs_cnt - cs0, 1);

    // ---------------- masking: feat=2 ----------------
    do_start(12'd1, 4'd2);
    check("mask_done_clr", done, 0);
    check("mask_des_en", bus.des_en, 1);
    repeat (2) step();
    send_word(all_ones);
    check("mask_data", bus.ram_wdata, 112'h0000_0000_0000_0000_FFFF_FFFF_FFFF);
    step();
    check("mask_core_start", bus.core_start, 1);
    step();
    finish_core();
    check("mask_done", done, 1);

    // ---------------- back-pressure on write 1 ----------------
    wr0 = wr_cnt;
    do_start(12'd2, 4'd6);
    send_word(mk_word(0));
    step();
    repeat (2) step();
    bus.ram_ready = 1'b0;
    w = mk_word(1);
    send_word(w);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d", c),
            {bus.ram_we, 6'(bus.ram_addr), bus.ram_wdata}, {1'b1, 6'd1, w});
      if (c < 4) step();
    end
    bus.ram_ready = 1'b1;
    step();
    check("bp_core_start", bus.core_start, 1);
    check("bp_we_drop", bus.ram_we, 0);
    check("bp_writes", wr_cnt - wr0, 2);
    step();
    finish_core();
    check("bp_done", done, 1);

    // ---------------- overflow with write pending ----------------
    cs0 = cs_cnt;
    do_start(12'd4, 4'd3);
    bus.ram_ready = 1'b0;
    send_word(mk_word(0));
    check("ovf_pending", bus.ram_we, 1);
    step();
    send_word(mk_word(1));
    check("ovf_err", err, 1);
    check("ovf_we", bus.ram_we, 0);
    check("ovf_busy_des", {busy, bus.des_en}, 2'b00);
    bus.ram_ready = 1'b1;
    repeat (3) step();
    check("ovf_err_hold", err, 1);
    check("ovf_no_cs", cs_cnt - cs0, 0);

    // overflow coinciding with the accept cycle
    do_start(12'd4, 4'd3);
    check("ovf2_err_clr", err, 0);
    send_word(mk_word(0));
    send_word(mk_word(1));
    check("ovf2_err", err, 1);
    check("ovf2_we", bus.ram_we, 0);

    // core_done outside RUN has no effect
    finish_core();
    check("ign_core_done", {done, err}, 2'b01);

    // ---------------- invalid configurations ----------------
    wr0 = wr_cnt;
    do_start(12'd4, 4'd7);
    check("inv_feat7", {err, bus.des_en, busy}, 3'b100);
    do_start(12'd4, 4'd0);
    check("inv_feat0", {err, bus.des_en, busy}, 3'b100);
    do_start(12'd0, 4'd3);
    check("inv_num0", {err, bus.des_en, busy}, 3'b100);
    do_start(12'd1025, 4'd3);
    check("inv_num1025", {err, bus.des_en, busy}, 3'b100);
    send_word(mk_word(2));
    step();
    check("inv_no_writes", wr_cnt - wr0, 0);
    do_start(12'd1024, 4'd1);
    check("inv_recover", {err, bus.des_en, busy}, 3'b011);
    send_word(mk_word(5));
    check("inv_rec_data", bus.ram_wdata, {80'h0, mk_word(5)[31:0]});

    // ---------------- asynchronous reset mid-WRITE ----------------
    step();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    do_start(12'd5, 4'd6);
    for (int i = 0; i < 3; i++) begin
      send_word(mk_word(i));
      step();
    end
    bus.ram_ready = 1'b0;
    send_word(mk_word(3));
    check("arst_pre", {bus.ram_we, 6'(bus.ram_addr)}, {1'b1, 6'd3});
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flags", {bus.des_en, bus.ram_we, bus.core_start, busy, done, err}, 6'b0);
    check("arst_addr_data", {6'(bus.ram_addr), bus.ram_wdata}, '0);
    step();
    rst_n = 1'b1;
    bus.ram_ready = 1'b1;
    step();
    send_word(mk_word(4));
    check("arst_idle", {bus.des_en, bus.ram_we, busy}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_dataset_load_ctrl

// File: doc/dataset_load_ctrl.md
# dataset_load_ctrl

Sequencer for the dataset-loading path of the regression engine. It enables the serial deserializer and takes each assembled data-point word (features plus y). It masks unused feature lanes and writes each word to the dataset RAM at consecutive addresses. After the last point it starts the compute core and reports completion or error. It sits between the deserializer, the dataset RAM write port and the compute core's start/done handshake.

## Interface

- MAX_FEATURES, 6, maximum feature count per data point
- DATA_WIDTH, 16*(MAX_FEATURES+1), word width (16-bit lanes; lane 0 = feature 0, lane feat = y)
- DEPTH, 1024, RAM depth in data points
- ADDR_WIDTH, 10, RAM address width
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- start  in  1  start request, sampled in IDLE/DONE/ERR
- num_dp  in  12  number of data points to load, latched on accepted start
- feat  in  4  feature count, latched on accepted start
- des_word  in  DATA_WIDTH  assembled word from deserializer
- des_valid  in  1  one-cycle strobe, des_word valid
- des_en  out  1  deserializer enable
- ram_we  out  1  RAM write request
- ram_ready  in  1  RAM accepts write when ram_we && ram_ready
- ram_addr  out  ADDR_WIDTH  write address
- ram_wdata  out  DATA_WIDTH  masked write data
- core_start  out  1  one-cycle pulse to compute core
- core_done  in  1  compute core completion strobe
- busy  out  1  high in LOAD, WRITE, START, RUN
- done  out  1  high in DONE
- err  out  1  high in ERR

## Operation

- States: IDLE, LOAD, WRITE, START, RUN, DONE, ERR.
- IDLE/DONE/ERR + start=1: latch num_dp and feat, then validate.
  - Go to ERR if feat==0, feat>MAX_FEATURES, num_dp==0 or num_dp>DEPTH.
  - Otherwise clear address and point counter and go to LOAD.
- LOAD: des_en=1. On des_valid, register masked word into ram_wdata, go to WRITE.
- Masking: lanes with index > feat are forced to 0. Lanes 0..feat pass unchanged.
- WRITE: des_en=1, ram_we=1, ram_addr/ram_wdata stable until accepted.
  - On accept, ram_addr increments and the counter increments.
  - If the counter reaches latched num_dp, go to START; otherwise go to LOAD.
  - des_valid while in WRITE (word arrives before the previous one is accepted) goes to ERR with the overflow flagged. The pending write is dropped and ram_we deasserts.
  - des_valid on the same cycle as the accept is also overflow and goes to ERR.
- START: core_start=1 for exactly one cycle, des_en=0, then RUN.
- RUN: wait for core_done, then DONE. des_valid in START/RUN is ignored.
- DONE: done=1 held until next accepted start. ERR: err=1 held until next accepted start or reset.
- start while busy is ignored. core_done outside RUN is ignored.
- Counter width 12 bits. ram_addr equals the counter's low ADDR_WIDTH bits, so no wrap within a valid run (num_dp ≤ DEPTH).

## Timing

- Reset (RST_N low, any state, asynchronous) forces IDLE. All outputs are 0: des_en, ram_we, ram_addr, ram_wdata, core_start, busy, done, err.
- start accepted at edge N: state LOAD and des_en=1 visible after edge N (cycle N+1). An invalid start gives err=1 at cycle N+1.
- des_valid at edge M in LOAD: ram_we=1 with data/addr from cycle M+1.
- With ram_ready tied 1, each write completes one cycle after ram_we rises. Minimum spacing between des_valid strobes is 2 cycles.
- Last write accepted at edge K: core_start high in cycle K+1 only, busy stays 1.
- core_done at edge J in RUN: done=1, busy=0 from cycle J+1.
- Start from DONE/ERR clears done/err in the same transition as entering LOAD.

## Test plan

- Reset mid-WRITE (ram_we=1, addr=3): drive RST_N low asynchronously. Every output is 0 immediately without a clock edge; after release, state is IDLE.
- Normal run, feat=6, num_dp=4, ram_ready=1, des_valid every 8 cycles: 4 writes at addr 0..3 with unmasked data. Then one core_start pulse, core_done, done=1.
- Masking, feat=2, des_word=all 0xFFFF lanes: ram_wdata lanes 0..2=0xFFFF, lanes 3..6=0x0000.
- Back-pressure: ram_ready low 5 cycles on write 1. ram_we, addr=1 and data are held stable, and the write is accepted on the first ready cycle.
- Overflow: des_valid while WRITE pending with ram_ready=0. err=1 next cycle, ram_we=0, no core_start.
- Invalid config: feat=7, or num_dp=0, or num_dp=1025. err=1 one cycle after start, no des_en, no RAM writes. A valid start afterwards clears err and loads normally.
